// File: rtl/divmod_request_arbiter.sv
// Round-robin front end that shares one pipelined divider among several clients.
// Requests carry a {div-by-zero, client index} tag that steers each result back to its client.
module divmod_request_arbiter #(
  parameter int  word_bits      = 32,
  parameter int  num_requesters = 4,
  localparam int idx_bits       = $clog2(num_requesters),
  localparam int tag_bits       = idx_bits + 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [num_requesters-1:0]           req_valid,
  output logic [num_requesters-1:0]           req_ready,
  input  logic [num_requesters*word_bits-1:0] req_divisor,
  input  logic [num_requesters*word_bits-1:0] req_dividend,
  output logic                                div_valid,
  input  logic                                div_ready,
  output logic [word_bits-1:0]                div_divisor,
  output logic [word_bits-1:0]                div_dividend,
  output logic [tag_bits-1:0]                 div_tag,
  input  logic                                div_ovalid,
  output logic                                div_oready,
  input  logic [word_bits-1:0]                div_quotient,
  input  logic [word_bits-1:0]                div_remainder,
  input  logic [tag_bits-1:0]                 div_otag,
  output logic [num_requesters-1:0]           rsp_valid,
  input  logic [num_requesters-1:0]           rsp_ready,
  output logic [word_bits-1:0]                rsp_quotient,
  output logic [word_bits-1:0]                rsp_remainder,
  output logic                                rsp_div_by_zero
);

  logic [idx_bits-1:0]       last_grant_q, last_grant_d;
  logic [idx_bits-1:0]       grant_idx;
  logic [idx_bits:0]         cand;
  logic                      grant_found;
  logic                      hit;
  logic [31:0]               grant_base;
  logic                      issue_free;
  logic                      accept;
  logic                      div_valid_q, div_valid_d;
  logic [word_bits-1:0]      div_divisor_q, div_divisor_d;
  logic [word_bits-1:0]      div_dividend_q, div_dividend_d;
  logic [tag_bits-1:0]       div_tag_q, div_tag_d;
  logic [num_requesters-1:0] rsp_valid_q, rsp_valid_d;
  logic [word_bits-1:0]      rsp_quotient_q, rsp_quotient_d;
  logic [word_bits-1:0]      rsp_remainder_q, rsp_remainder_d;
  logic                      rsp_dbz_q, rsp_dbz_d;
  logic                      rsp_fire;
  logic                      res_accept;
  logic [idx_bits-1:0]       otag_idx;
  logic                      tag_in_range;

  assign issue_free = !div_valid_q || div_ready;
  assign accept     = !reset && issue_free && grant_found;
  assign grant_base = 32'(grant_idx) * 32'(word_bits);

  // Round-robin search starting one past the last accepted client.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = {idx_bits{1'b0}};
    cand        = {(idx_bits+1){1'b0}};
    hit         = 1'b0;
    for (int k = 0; k < num_requesters; k++) begin
      cand = {1'b0, last_grant_q} + (idx_bits+1)'(k + 1);
      cand = (cand >= (idx_bits+1)'(num_requesters)) ? cand - (idx_bits+1)'(num_requesters) : cand;
      hit  = !grant_found && req_valid[cand[idx_bits-1:0]];
      grant_idx   = hit ? cand[idx_bits-1:0] : grant_idx;
      grant_found = grant_found | hit;
    end
  end

  // One-hot accept strobe to the granted client.
  always_comb begin
    req_ready = {num_requesters{1'b0}};
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end else begin
      req_ready = {num_requesters{1'b0}};
    end
  end

  // Issue slot next state: a new accept overwrites a draining entry.
  always_comb begin
    div_valid_d    = div_valid_q;
    div_divisor_d  = div_divisor_q;
    div_dividend_d = div_dividend_q;
    div_tag_d      = div_tag_q;
    last_grant_d   = last_grant_q;
    if (accept) begin
      div_valid_d    = 1'b1;
      div_divisor_d  = req_divisor[grant_base +: word_bits];
      div_dividend_d = req_dividend[grant_base +: word_bits];
      div_tag_d      = {(div_divisor_d == {word_bits{1'b0}}), grant_idx};
      last_grant_d   = grant_idx;
    end else if (div_ready) begin
      div_valid_d = 1'b0;
    end else begin
      div_valid_d = div_valid_q;
    end
  end

  // Issue slot and arbitration pointer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_valid_q    <= 1'b0;
      div_divisor_q  <= {word_bits{1'b0}};
      div_dividend_q <= {word_bits{1'b0}};
      div_tag_q      <= {tag_bits{1'b0}};
      last_grant_q   <= idx_bits'(num_requesters - 1);
    end else begin
      div_valid_q    <= div_valid_d;
      div_divisor_q  <= div_divisor_d;
      div_dividend_q <= div_dividend_d;
      div_tag_q      <= div_tag_d;
      last_grant_q   <= last_grant_d;
    end
  end

  assign rsp_fire     = |(rsp_valid_q & rsp_ready);
  assign div_oready   = !reset && (!(|rsp_valid_q) || rsp_fire);
  assign res_accept   = div_ovalid && div_oready;
  assign otag_idx     = div_otag[idx_bits-1:0];
  // Out-of-range indices are consumed from the divider but never presented.
  assign tag_in_range = ({1'b0, otag_idx} < (idx_bits+1)'(num_requesters));

  // Response slot next state: a new result overwrites a draining entry.
  always_comb begin
    rsp_valid_d     = rsp_valid_q;
    rsp_quotient_d  = rsp_quotient_q;
    rsp_remainder_d = rsp_remainder_q;
    rsp_dbz_d       = rsp_dbz_q;
    if (res_accept && tag_in_range) begin
      rsp_valid_d           = {num_requesters{1'b0}};
      rsp_valid_d[otag_idx] = 1'b1;
      rsp_quotient_d        = div_quotient;
      rsp_remainder_d       = div_remainder;
      rsp_dbz_d             = div_otag[tag_bits-1];
    end else if (rsp_fire || res_accept) begin
      rsp_valid_d = rsp_fire ? {num_requesters{1'b0}} : rsp_valid_q;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Response slot registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid_q     <= {num_requesters{1'b0}};
      rsp_quotient_q  <= {word_bits{1'b0}};
      rsp_remainder_q <= {word_bits{1'b0}};
      rsp_dbz_q       <= 1'b0;
    end else begin
      rsp_valid_q     <= rsp_valid_d;
      rsp_quotient_q  <= rsp_quotient_d;
      rsp_remainder_q <= rsp_remainder_d;
      rsp_dbz_q       <= rsp_dbz_d;
    end
  end

  assign div_valid       = div_valid_q;
  assign div_divisor     = div_divisor_q;
  assign div_dividend    = div_dividend_q;
  assign div_tag         = div_tag_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_quotient    = rsp_quotient_q;
  assign rsp_remainder   = rsp_remainder_q;
  assign rsp_div_by_zero = rsp_dbz_q;

endmodule

// File: tb/tb_divmod_request_arbiter.sv
// Bench for divmod_request_arbiter: behavioural 33-stage divider, issue-order scoreboard,
// directed grant-order table, hand-written latency/backpressure/reset sequences and a random soak.
module tb_divmod_request_arbiter;
  localparam int W   = 32;
  localparam int N   = 4;
  localparam int TBW = 3;
  localparam int NST = W + 1;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_divisor, req_dividend;
  logic           div_valid, div_ready;
  logic [W-1:0]   div_divisor, div_dividend;
  logic [TBW-1:0] div_tag;
  logic           div_ovalid, div_oready;
  logic [W-1:0]   div_quotient, div_remainder;
  logic [TBW-1:0] div_otag;
  logic [N-1:0]   rsp_valid, rsp_ready;
  logic [W-1:0]   rsp_quotient, rsp_remainder;
  logic           rsp_div_by_zero;

  logic in_stall, out_hold;
  int   checks = 0;
  int   errors = 0;

  divmod_request_arbiter #(.word_bits(W), .num_requesters(N)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_divisor(req_divisor), .req_dividend(req_dividend),
    .div_valid(div_valid), .div_ready(div_ready),
    .div_divisor(div_divisor), .div_dividend(div_dividend), .div_tag(div_tag),
    .div_ovalid(div_ovalid), .div_oready(div_oready),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_otag(div_otag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_div_by_zero(rsp_div_by_zero)
  );

  always #5 clock = ~clock;

  // Behavioural divider: NST stages, whole pipe stalls when its output is blocked.
  logic           st_v [NST];
  logic [W-1:0]   st_q [NST];
  logic [W-1:0]   st_r [NST];
  logic [TBW-1:0] st_t [NST];
  logic           adv;

  assign adv           = !st_v[NST-1] || (div_oready && !out_hold);
  assign div_ready     = adv && !in_stall;
  assign div_ovalid    = st_v[NST-1] && !out_hold;
  assign div_quotient  = st_q[NST-1];
  assign div_remainder = st_r[NST-1];
  assign div_otag      = st_t[NST-1];

  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NST; k++) st_v[k] <= 1'b0;
    end else if (adv) begin
      for (int k = NST - 1; k > 0; k--) begin
        st_v[k] <= st_v[k-1];
        st_q[k] <= st_q[k-1];
        st_r[k] <= st_r[k-1];
        st_t[k] <= st_t[k-1];
      end
      st_v[0] <= div_valid && div_ready;
      st_q[0] <= (div_divisor == 32'd0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
      st_r[0] <= (div_divisor == 32'd0) ? div_dividend : div_dividend % div_divisor;
      st_t[0] <= div_tag;
    end
  end

  typedef struct {
    int           idx;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_ci;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t model(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.idx = idx;
    e.dbz = (b == 32'd0);
    e.q   = e.dbz ? 32'hFFFF_FFFF : a / b;
    e.r   = e.dbz ? a : a % b;
    return e;
  endfunction

  // Scoreboard: results must come back in global issue order to the right client.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (|(rsp_valid & rsp_ready)) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_client", 64'(rsp_valid), 64'(1) << mon_e.idx);
          chk("rsp_quotient", 64'(rsp_quotient), 64'(mon_e.q));
          chk("rsp_remainder", 64'(rsp_remainder), 64'(mon_e.r));
          chk("rsp_dbz", 64'(rsp_div_by_zero), 64'(mon_e.dbz));
        end
      end
      if (|(req_valid & req_ready)) begin
        mon_ci = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) mon_ci = i;
        exp_q.push_back(model(mon_ci, req_dividend[mon_ci*W +: W], req_divisor[mon_ci*W +: W]));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ops(input int c, input logic [W-1:0] a, input logic [W-1:0] b);
    req_dividend[c*W +: W] = a;
    req_divisor[c*W +: W]  = b;
  endtask

  // Single isolated request; checks issue latency, tag and end-to-end timing.
  task automatic one_shot(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TBW-1:0] etag, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic edbz);
    int n;
    set_ops(c, a, b);
    req_valid = N'(1) << c;
    #1;
    chk("single_req_ready", 64'(req_ready), 64'(1) << c);
    tick();
    req_valid = 4'b0000;
    chk("single_div_valid", 64'(div_valid), 64'd1);
    chk("single_div_tag", 64'(div_tag), 64'(etag));
    n = 1;
    while (!rsp_valid[c] && n < 80) begin
      tick();
      n++;
    end
    chk("single_latency", 64'(n), 64'(W + 3));
    chk("single_quotient", 64'(rsp_quotient), 64'(eq));
    chk("single_remainder", 64'(rsp_remainder), 64'(er));
    chk("single_dbz", 64'(rsp_div_by_zero), 64'(edbz));
  endtask

  typedef struct {
    logic [N-1:0]   rv;
    logic           stall;
    logic [N-1:0]   rr;
    logic           dv;
    logic [TBW-1:0] tag;
  } vec_t;

  vec_t vt[17];

  initial begin
    int n, seen, issued, cyc;
    logic [N-1:0] pend, acc;
    int sel;

    vt[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b0, 3'd0};
    vt[1]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 3'd0};
    vt[2]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 3'd1};
    vt[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 3'd2};
    vt[4]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 3'd3};
    vt[5]  = '{4'b1011, 1'b0, 4'b0010, 1'b1, 3'd0};
    vt[6]  = '{4'b1011, 1'b0, 4'b1000, 1'b1, 3'd1};
    vt[7]  = '{4'b1011, 1'b0, 4'b0001, 1'b1, 3'd3};
    vt[8]  = '{4'b1011, 1'b0, 4'b0010, 1'b1, 3'd0};
    for (int i = 9; i < 14; i++) vt[i] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 3'd1};
    vt[14] = '{4'b1111, 1'b0, 4'b0100, 1'b1, 3'd1};
    vt[15] = '{4'b1111, 1'b0, 4'b1000, 1'b1, 3'd2};
    vt[16] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 3'd3};

    reset     = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    in_stall  = 1'b0;
    out_hold  = 1'b0;
    for (int i = 0; i < N; i++) set_ops(i, 32'(1000 + i * 17), 32'(i + 1));
    tick();
    tick();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_div_valid", 64'(div_valid), 64'd0);
    chk("rst_div_divisor", 64'(div_divisor), 64'd0);
    chk("rst_div_dividend", 64'(div_dividend), 64'd0);
    chk("rst_div_tag", 64'(div_tag), 64'd0);
    chk("rst_div_oready", 64'(div_oready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_quotient", 64'(rsp_quotient), 64'd0);
    chk("rst_rsp_remainder", 64'(rsp_remainder), 64'd0);
    chk("rst_rsp_dbz", 64'(rsp_div_by_zero), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      req_valid = vt[i].rv;
      in_stall  = vt[i].stall;
      #1;
      chk("rr_req_ready", 64'(req_ready), 64'(vt[i].rr));
      chk("rr_div_valid", 64'(div_valid), 64'(vt[i].dv));
      if (vt[i].dv) begin
        chk("rr_div_tag", 64'(div_tag), 64'(vt[i].tag));
        chk("rr_div_divisor", 64'(div_divisor), 64'(vt[i].tag[1:0]) + 64'd1);
      end
      tick();
    end
    repeat (45) tick();
    chk("rr_drained", 64'(exp_q.size()), 64'd0);

    one_shot(1, 32'd100, 32'd7, 3'b001, 32'd14, 32'd2, 1'b0);
    tick();
    one_shot(3, 32'd5, 32'd0, 3'b111, 32'hFFFF_FFFF, 32'd5, 1'b1);
    tick();

    // Client 2 result held off while a client 0 result queues behind it.
    rsp_ready = 4'b1011;
    set_ops(2, 32'd50, 32'd3);
    req_valid = 4'b0100;
    #1;
    chk("bp_grant2", 64'(req_ready), 64'b0100);
    tick();
    set_ops(0, 32'd9, 32'd2);
    req_valid = 4'b0001;
    #1;
    chk("bp_grant0", 64'(req_ready), 64'b0001);
    tick();
    req_valid = 4'b0000;
    n = 0;
    while (!rsp_valid[2] && n < 80) begin
      tick();
      n++;
    end
    chk("bp_arrive", 64'(rsp_valid[2]), 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", 64'(rsp_valid), 64'b0100);
      chk("bp_hold_quotient", 64'(rsp_quotient), 64'd16);
      chk("bp_hold_remainder", 64'(rsp_remainder), 64'd2);
      chk("bp_hold_oready", 64'(div_oready), 64'd0);
      tick();
    end
    rsp_ready = 4'b1111;
    #1;
    chk("bp_release_oready", 64'(div_oready), 64'd1);
    tick();
    chk("bp_next_valid", 64'(rsp_valid), 64'b0001);
    chk("bp_next_quotient", 64'(rsp_quotient), 64'd4);
    chk("bp_next_remainder", 64'(rsp_remainder), 64'd1);
    repeat (5) tick();
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of an in-flight request.
    set_ops(0, 32'd5, 32'd1);
    req_valid = 4'b0001;
    tick();
    chk("mid_div_valid", 64'(div_valid), 64'd1);
    reset     = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("mid_req_ready", 64'(req_ready), 64'd0);
    chk("mid_oready", 64'(div_oready), 64'd0);
    tick();
    chk("mid_flushed_div", 64'(div_valid), 64'd0);
    chk("mid_flushed_rsp", 64'(rsp_valid), 64'd0);
    reset     = 1'b0;
    req_valid = 4'b0000;
    seen      = 0;
    repeat (40) begin
      if (|rsp_valid) seen++;
      tick();
    end
    chk("mid_no_stale_rsp", 64'(seen), 64'd0);
    req_valid = 4'b1111;
    #1;
    chk("mid_first_grant", 64'(req_ready), 64'b0001);

    // Random soak with backpressure on every interface.
    pend   = 4'b0000;
    issued = 0;
    cyc    = 0;
    while (issued < 10000 && cyc < 70000) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          sel = $urandom_range(0, 9);
          set_ops(i, $urandom, (sel == 0) ? 32'd0 : (sel < 4) ? 32'($urandom_range(1, 15)) : $urandom);
        end
      end
      req_valid = pend;
      for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
      in_stall = ($urandom_range(0, 4) == 0);
      out_hold = ($urandom_range(0, 9) == 0);
      #1;
      acc     = req_valid & req_ready;
      issued += $countones(acc);
      pend    = pend & ~acc;
      tick();
      cyc++;
    end
    chk("soak_issued", 64'(issued >= 10000), 64'd1);
    req_valid = 4'b0000;
    rsp_ready = 4'b1111;
    in_stall  = 1'b0;
    out_hold  = 1'b0;
    repeat (60) tick();
    chk("soak_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
